muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle datapath, generalising the separate fixed-width mult and div blocks. It serves all four MIPS operations: mult, multu, div and divu. Operands come from the A/B registers. Results land in internal Hi/Lo registers that the datapath reads directly, with a single start/busy/done handshake for the control unit.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; legal values ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation, sampled with start: 00 = mult, 01 = multu, 10 = div, 11 = divu.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- hi  out  WIDTH  product upper half / remainder.
- lo  out  WIDTH  product lower half / quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo hold new results.
- div_zero  out  1  divide-by-zero flag for the last accepted operation.
- abort  in  1  present only with MULDIV_ABORT_EN.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE → RUN** on an edge where start = 1:
  - latches op;
  - latches |a| and |b| for signed ops, raw a and b for unsigned ops;
  - latches the result-sign bits;
  - loads iteration counter = WIDTH;
  - clears div_zero.
- **Divide by zero:** for div/divu with b == 0, IDLE goes directly to DONE instead.
  - div_zero = 1.
  - hi/lo are not written.
- **RUN:** one iteration per cycle, counter decrements, RUN → FIX when the counter reaches 0.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
- **FIX:** one cycle, then FIX → DONE.
  - Applies sign correction: product negated if sign(a) ≠ sign(b); quotient negated if signs differ; remainder takes the sign of the dividend.
  - Writes hi/lo.
- **DONE:** done = 1 for exactly one cycle, then DONE → IDLE unconditionally.
- Results:
  - Multiply: {hi, lo} = full 2·WIDTH product.
  - Divide: lo = quotient truncated toward zero, hi = remainder.
- Signed overflow (most-negative ÷ −1): lo = most-negative value (wrap), hi = 0. No flag.
- start while busy, in FIX or in DONE is ignored; it is not queued.
- hi/lo hold their value between operations. They change only in FIX or on reset.
- div_zero holds until the next accepted start or reset.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state = IDLE.
- start accepted at edge k.
  - busy = 1 from after edge k through edge k+WIDTH+1.
  - FIX is executed at edge k+WIDTH+1.
  - done = 1 and hi/lo valid in the cycle following edge k+WIDTH+1.
  - Total latency: WIDTH+2 edges.
- Divide-by-zero path: done = 1 and div_zero = 1 in the cycle after edge k. busy stays 0.
- Earliest next accepted start: the edge that returns DONE → IDLE plus one. In-flight spacing is WIDTH+3 cycles.
- Reset mid-operation (any state) returns the block to reset values at that edge. No done pulse is issued.
- Counter width: $clog2(WIDTH+1).

## Configuration
- MULDIV_ABORT_EN defined:
  - adds the abort input;
  - abort = 1 in RUN or FIX forces IDLE at that edge;
  - busy = 0 next cycle, no done pulse;
  - hi/lo and div_zero are unchanged;
  - abort has priority over start; reset has priority over abort.
- MULDIV_ABORT_EN undefined: no abort port, and an operation always runs to completion.

## Test plan
- mult, a = 0xFFFFFFFD, b = 7 → done after 34 edges, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- multu, a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. A start pulsed mid-run must not change the result or extend busy.
- div, a = 0xFFFFFFF9, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Then div, a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- divu, a = 7, b = 0, with hi/lo preloaded from a prior op → done and div_zero the next cycle, busy never high, hi/lo unchanged. The next accepted start clears div_zero.
- reset held one cycle at RUN iteration 10 → next cycle busy = 0, hi = lo = 0, no done. A fresh multu 6 × 7 then gives lo = 42, hi = 0.
- MULDIV_ABORT_EN: abort at iteration 5 of divu 100/7 → IDLE next cycle, no done, prior hi/lo kept. Rerun without abort → lo = 14, hi = 2.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide, with Hi/Lo result registers.
// Optional abort input enabled by defining MULDIV_ABORT_EN.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
`ifdef MULDIV_ABORT_EN
   input  logic             i_abort,
`endif
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

   state_t             r_state;
   logic               r_is_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_div_zero;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic               w_div_zero;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_trial;
   logic [2*WIDTH-1:0] w_step;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // op[0] = 0 selects the signed variants
   assign w_a_neg    = i_a[WIDTH-1] & ~i_op[0];
   assign w_b_neg    = i_b[WIDTH-1] & ~i_op[0];
   assign w_a_abs    = w_a_neg ? -i_a : i_a;
   assign w_b_abs    = w_b_neg ? -i_b : i_b;
   assign w_div_zero = i_op[1] & (i_b == '0);

   // Multiply: accumulator low half holds the multiplier, shifted out LSB first.
   // Divide: accumulator holds {remainder, dividend/quotient}, shifted left.
   assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};

   always_comb begin
      w_step = '0;
      if (!r_is_div) begin
         w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
      end else if (!w_div_trial[WIDTH]) begin
         w_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
   end

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end
`ifdef MULDIV_ABORT_EN
      else if (i_abort && (r_state == StRun || r_state == StFix)) begin
         r_state <= StIdle;
         r_busy  <= 1'b0;
      end
`endif
      else begin
         unique case (r_state)
            StIdle: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_is_div   <= i_op[1];
                  r_div_zero <= 1'b0;
                  if (w_div_zero) begin
                     r_div_zero <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= StDone;
                  end else begin
                     r_a       <= w_a_abs;
                     r_b       <= w_b_abs;
                     r_acc     <= i_op[1] ? {{WIDTH{1'b0}}, w_a_abs} : {{WIDTH{1'b0}}, w_b_abs};
                     r_neg_res <= w_a_neg ^ w_b_neg;
                     r_neg_rem <= w_a_neg;
                     r_cnt     <= CW'(WIDTH);
                     r_busy    <= 1'b1;
                     r_state   <= StRun;
                  end
               end
            end
            StRun: begin
               r_acc <= w_step;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= StFix;
               end
            end
            StFix: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= StDone;
            end
            StDone: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;

endmodule
